// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes
// them to instruction memory from word 0, holding the CPU in reset until loaded.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.

module imem_loader #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  // state | meaning
  // IDLE  | waiting for the first start
  // LEN0  | accepting word-count low byte
  // LEN1  | accepting word-count high byte, range check
  // DATA  | accepting data bytes of the current word
  // WR    | write pulse cycle, decides next word or end of frame
  // CSUM  | accepting the checksum byte (checksum build only)
  // DONE  | program loaded, CPU released
  // ERR   | load aborted, CPU held in reset
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LEN0 = 3'd1;
  localparam logic [2:0] LEN1 = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] DONE = 3'd6;
  localparam logic [2:0] ERR  = 3'd7;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM = 3'd5;
  localparam logic [2:0] AFTER_DATA = CSUM;
`else
  localparam logic [2:0] AFTER_DATA = DONE;
`endif

  localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(1 << ADDR_W);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             rdy_nxt;
  logic             busy_nxt;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] hdr_n;
  logic [1:0]       byte_idx;
  logic [23:0]      word_buf;
  logic             acc;
  logic             last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign acc       = rx_valid && rx_ready;
  assign hdr_n     = CNT_W'({rx_data, len[7:0]});
  assign last_word = (CNT_W'(words_loaded) == len);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LEN0;
      LEN0: if (acc) state_nxt = LEN1;
      LEN1: begin
        if (acc) begin
          if (hdr_n > DEPTH_N) state_nxt = ERR;
          else if (hdr_n == '0) state_nxt = AFTER_DATA;
          else state_nxt = DATA;
        end
      end
      DATA: if (acc && byte_idx == 2'd3) state_nxt = WR;
      WR:   state_nxt = last_word ? AFTER_DATA : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (acc) state_nxt = (rx_data == csum) ? DONE : ERR;
`endif
      DONE, ERR: if (start) state_nxt = LEN0;
      default: state_nxt = IDLE;
    endcase

    rdy_nxt = (state_nxt == LEN0) || (state_nxt == LEN1) || (state_nxt == DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state_nxt == CSUM) rdy_nxt = 1'b1;
`endif
    busy_nxt = rdy_nxt || (state_nxt == WR);
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      rx_ready     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      cpu_rstn     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      state    <= state_nxt;
      rx_ready <= rdy_nxt;
      busy     <= busy_nxt;
      done     <= (state_nxt == DONE);
      cpu_rstn <= (state_nxt == DONE);
      err      <= (state_nxt == ERR);
      im_we    <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            words_loaded <= '0;
            len          <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end
        LEN0: if (acc) len <= CNT_W'(rx_data);
        LEN1: if (acc) len <= hdr_n;
        DATA: begin
          if (acc) begin
            byte_idx <= byte_idx + 2'd1;
            word_buf <= {rx_data, word_buf[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
            if (byte_idx == 2'd3) begin
              im_we        <= 1'b1;
              im_addr      <= words_loaded[ADDR_W-1:0];
              im_wdata     <= {rx_data, word_buf};
              words_loaded <= words_loaded + (ADDR_W+1)'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of directed frames, hand-written corner sequences,
// and random frames checked against a frame-level reference model.

module tb_imem_loader;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rstn;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log and end-of-load timing, sampled mid-cycle.
  logic [38:0] wlog[$];
  int   last_we_cyc = -1;
  int   term_cyc    = -1;
  int   we_long     = 0;
  logic prev_we     = 1'b0;
  logic prev_term   = 1'b0;
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wlog.push_back({im_addr, im_wdata});
      last_we_cyc <= cyc;
      if (prev_we) we_long <= we_long + 1;
    end
    prev_we <= (im_we === 1'b1);
    if ((done === 1'b1 || err === 1'b1) && !prev_term) term_cyc <= cyc;
    prev_term <= (done === 1'b1 || err === 1'b1);
  end

  logic [7:0]  frame[$];
  int          gaps[$];
  logic [31:0] exp_w[$];
  int          mid_start = -1;

  typedef struct {
    logic [95:0] bytes;
    int          nb;
    int          ga_at;
    int          ga_len;
    int          gb_at;
    int          gb_len;
    bit          e_done;
    bit          e_err;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":rx_ready"}, rx_ready, 0);
    chk({tag, ":im_we"}, im_we, 0);
    chk({tag, ":im_addr"}, im_addr, 0);
    chk({tag, ":im_wdata"}, im_wdata, 0);
    chk({tag, ":cpu_rstn"}, cpu_rstn, 0);
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":done"}, done, 0);
    chk({tag, ":err"}, err, 0);
    chk({tag, ":words_loaded"}, words_loaded, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL rx_accept: byte 0x%h never accepted, rx_ready=%b, expected 1", b, rx_ready);
      acc_cyc = -1;
    end else begin
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input string nm, input bit e_done, input bit e_err);
    int base;
    int acc_cyc;
    int n;
    int exp_t;
    bit tout;
    tout    = 1'b0;
    acc_cyc = -1;
    pulse_start();
    chk({nm, ":busy_after_start"}, busy, 1);
    chk({nm, ":ready_after_start"}, rx_ready, 1);
    chk({nm, ":done_cleared"}, done, 0);
    chk({nm, ":cpu_rstn_cleared"}, cpu_rstn, 0);
    chk({nm, ":words_cleared"}, words_loaded, 0);
    base = wlog.size();
    for (int i = 0; i < frame.size(); i++) begin
      if (tout) break;
      if (i == mid_start) pulse_start();
      if (i < gaps.size()) repeat (gaps[i]) @(negedge clk);
      send_byte(frame[i], acc_cyc);
      if (acc_cyc < 0) tout = 1'b1;
    end
    n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk({nm, ":done"}, done, e_done);
    chk({nm, ":err"}, err, e_err);
    chk({nm, ":cpu_rstn"}, cpu_rstn, e_done);
    chk({nm, ":busy_end"}, busy, 0);
    chk({nm, ":ready_end"}, rx_ready, 0);
    chk({nm, ":words_loaded"}, words_loaded, exp_w.size());
    chk({nm, ":write_count"}, wlog.size() - base, exp_w.size());
    for (int i = 0; i < exp_w.size(); i++) begin
      if (base + i < wlog.size()) begin
        chk($sformatf("%s:addr%0d", nm, i), wlog[base+i][38:32], i);
        chk($sformatf("%s:data%0d", nm, i), wlog[base+i][31:0], exp_w[i]);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_t = acc_cyc;
`else
    exp_t = (exp_w.size() > 0) ? last_we_cyc + 1 : acc_cyc;
`endif
    chk({nm, ":end_timing"}, term_cyc, exp_t);
    mid_start = -1;
  endtask

  task automatic load_nominal();
    frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    frame.push_back(8'hF0);
`endif
    gaps.delete();
    foreach (frame[i]) gaps.push_back(0);
    exp_w = '{32'h00500013, 32'h000000B3};
  endtask

  task automatic gen_frame(input int n);
    frame.delete();
    gaps.delete();
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    if (n <= 128) begin
      for (int k = 0; k < 4 * n; k++) frame.push_back(8'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
      begin
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < 4 * n; k++) x = x ^ frame[2+k];
        if ($urandom_range(0, 2) == 0) x = x ^ 8'($urandom_range(1, 255));
        frame.push_back(x);
      end
`endif
    end
    foreach (frame[i]) gaps.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
  endtask

  // Frame-level reference: header decides range, data bytes form LE words.
  task automatic model_frame(output bit e_done, output bit e_err);
    int n;
    exp_w.delete();
    n = int'(frame[0]) + 256 * int'(frame[1]);
    if (n > 128) begin
      e_done = 1'b0;
      e_err  = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++)
      exp_w.push_back({frame[2+4*w+3], frame[2+4*w+2], frame[2+4*w+1], frame[2+4*w]});
`ifdef IMEM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int k = 0; k < 4 * n; k++) x = x ^ frame[2+k];
      e_done = (frame[2+4*n] == x);
      e_err  = !e_done;
    end
`else
    e_done = 1'b1;
    e_err  = 1'b0;
`endif
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation still running at time limit, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int a;
    bit d;
    bit e;

    vecs[0] = '{96'h00000000_00B30050_00130002, 10, -1, 0, -1, 0, 1'b1, 1'b0, 2, 32'h00500013, 32'h000000B3};
    vecs[1] = '{96'h00000000_00B30050_00130002, 10,  4, 5,  6, 3, 1'b1, 1'b0, 2, 32'h00500013, 32'h000000B3};
    vecs[2] = '{96'h00000000_00000000_00000081,  2, -1, 0, -1, 0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[3] = '{96'h00000000_0000DEAD_BEEF0001,  6, -1, 0, -1, 0, 1'b1, 1'b0, 1, 32'hDEADBEEF, 32'h0};
    vecs[4] = '{96'h00000000_00000000_00000000,  2, -1, 0, -1, 0, 1'b1, 1'b0, 0, 32'h0, 32'h0};
    vecs[5] = '{96'h00000000_00000000_00000100,  2, -1, 0, -1, 0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[6] = '{96'h00000000_00B30050_00130002, 10,  3, 2, -1, 0, 1'b1, 1'b0, 2, 32'h00500013, 32'h000000B3};

    rstn     = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 7; t++) begin
      frame.delete();
      gaps.delete();
      exp_w.delete();
      for (int j = 0; j < vecs[t].nb; j++) begin
        frame.push_back(vecs[t].bytes[8*j +: 8]);
        gaps.push_back((j == vecs[t].ga_at) ? vecs[t].ga_len : (j == vecs[t].gb_at) ? vecs[t].gb_len : 0);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!vecs[t].e_err) begin
        logic [7:0] x;
        x = 8'h00;
        for (int j = 2; j < vecs[t].nb; j++) x = x ^ frame[j];
        frame.push_back(x);
        gaps.push_back(0);
      end
`endif
      if (vecs[t].nw > 0) exp_w.push_back(vecs[t].w0);
      if (vecs[t].nw > 1) exp_w.push_back(vecs[t].w1);
      run_frame($sformatf("vec%0d", t), vecs[t].e_done, vecs[t].e_err);
    end

    // Bytes offered while loaded are refused.
    base     = wlog.size();
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("idle_refuse%0d", i), rx_ready, 0);
    end
    rx_valid = 1'b0;
    chk("idle_refuse:done_held", done, 1);
    chk("idle_refuse:no_write", wlog.size() - base, 0);

    // start while busy is ignored.
    load_nominal();
    mid_start = 5;
    run_frame("busy_start", 1'b1, 1'b0);

    // Reset after three bytes of word 1, then a clean reload.
    load_nominal();
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(frame[i], a);
    rstn = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rstn = 1'b1;
    @(negedge clk);
    run_frame("after_reset", 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    load_nominal();
    frame[10] = 8'hF1;
    run_frame("csum_bad", 1'b0, 1'b1);
    load_nominal();
    run_frame("csum_good", 1'b1, 1'b0);
`endif

    for (int r = 0; r < 10; r++) begin
      int n;
      if (r == 6) n = 128;
      else if (r == 7) n = int'($urandom_range(129, 65535));
      else if (r == 5) n = 0;
      else n = int'($urandom_range(1, 6));
      gen_frame(n);
      model_frame(d, e);
      run_frame($sformatf("rnd%0d_n%0d", r, n), d, e);
    end

    chk("im_we_single_cycle", we_long, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Hardware program loader: the writer side of instruction memory, replacing simulation-time hex loading.
- Accepts a byte stream over a valid/ready handshake (e.g. from a UART receiver) and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction-memory write port, starting at word 0.
- Holds the single-cycle CPU in reset until the load completes, then releases it.

Parameters:
- ADDR_W, 7, instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words (128).
- CNT_W, 16, width of the word-count header field.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse: arm a new load.
- rx_valid  input  1  byte available on rx_data.
- rx_data  input  8  stream byte.
- rx_ready  output  1  loader can accept a byte this cycle.
- im_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- im_addr  output  ADDR_W  word address of the write.
- im_wdata  output  32  instruction word.
- cpu_rstn  output  1  active-low reset to the CPU; 0 while not loaded.
- busy  output  1  load in progress.
- done  output  1  load completed successfully.
- err  output  1  load aborted.
- words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset: when rstn=0 at a clock edge, every output goes to 0 (rx_ready, im_we, im_addr, im_wdata, cpu_rstn, busy, done, err, words_loaded). State goes to IDLE. Partial word, byte index, length and checksum are cleared.
- Reset mid-load discards all progress; nothing already written to memory is undone.
- A byte is accepted only on a cycle where rx_valid=1 and rx_ready=1. rx_ready is registered: it is 1 in LEN0, LEN1, DATA and CSUM, and 0 in all other states.
- Frame format: LEN low byte, LEN high byte (N = word count), then 4N data bytes. Within each word the bytes are little-endian (the first byte is bits 7:0).
- States and transitions:
  - IDLE: waits for start, then goes to LEN0.
  - LEN0: accepts the LEN low byte, then goes to LEN1.
  - LEN1: accepts the LEN high byte, then:
    - N > DEPTH: go to ERR.
    - N = 0: go to CSUM if the checksum feature is enabled, otherwise DONE.
    - otherwise: go to DATA.
  - DATA: accepts bytes into byte_idx 0..3. On accepting byte 3:
    - the next cycle has im_we=1, im_addr = current word index, im_wdata = assembled word;
    - the word index and words_loaded both increment.
    - After word N-1 is written, go to CSUM or DONE.
  - CSUM: accepts the checksum byte; match goes to DONE, mismatch goes to ERR.
  - DONE: done=1 and cpu_rstn=1, asserted exactly one cycle after the final im_we pulse (or one cycle after the last header/checksum byte when N=0). busy=0.
  - ERR: err=1, cpu_rstn=0, busy=0. No further im_we.
- busy=1 in LEN0, LEN1, DATA and CSUM.
- start in DONE or ERR:
  - next state is LEN0;
  - done, err and cpu_rstn drop to 0 on the next cycle;
  - word index, words_loaded and checksum clear.
- start while busy is ignored.
- rx_valid gaps anywhere in a frame: the partial word and byte_idx hold indefinitely. No timeout.
- im_we is never asserted for more than one cycle per word.
- The word index never wraps, because N ≤ DEPTH is enforced before DATA.
- Bytes offered outside the busy states are not accepted (rx_ready=0).

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - the frame carries one trailing checksum byte, equal to the XOR of all 4N data bytes (the header is excluded);
  - for N=0 the expected checksum is 0x00;
  - a mismatch ends in ERR with cpu_rstn held at 0.
- Undefined: the CSUM state and the checksum register do not exist, and the loader goes directly from the last word (or from N=0) to DONE.

Test Plan:
- Nominal two-word load: reset, start, then bytes 02 00 13 00 50 00 B3 00 00 00 with continuous rx_valid.
  - Expect im_we at addr 0 with data 0x00500013, then at addr 1 with data 0x000000B3.
  - One cycle after the second pulse: done=1, cpu_rstn=1, words_loaded=2, rx_ready=0.
- Stalls: same frame with rx_valid low for 5 cycles between the 2nd and 3rd data bytes, and for 3 cycles between words. Expect identical writes, exactly 2 im_we pulses, and no write during the stalls.
- Oversize header with ADDR_W=7: bytes 81 00 (N=129). Expect err=1 after LEN1, rx_ready=0, cpu_rstn=0, no im_we. Then start followed by a valid frame loads normally.
- Empty program: bytes 00 00 (checksum macro undefined). Expect done=1 and cpu_rstn=1 one cycle after LEN1 is accepted, no im_we, words_loaded=0.
- Reset mid-load: assert rstn=0 after 3 bytes of word 1 of the nominal frame. Expect all outputs 0. Then start plus the full frame gives the same writes as the nominal case, starting at addr 0.
- With IMEM_LOADER_CHECKSUM_EN:
  - nominal frame followed by F0 → done=1, cpu_rstn=1;
  - nominal frame followed by F1 → err=1, cpu_rstn=0, with both words still written.
